// File: rtl/alu_issue_ctrl_pkg.sv
// ============================================================================
// Module      : alu_issue_ctrl_pkg
// Description : Shared ALU op codes, instruction opcodes, sequencer state
//               encoding and the opcode decoder used by alu_issue_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_issue_ctrl_pkg;

    // ALU op codes, as understood by the combinational ALU
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_XOR = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_SLL = 4'd12;
    localparam logic [3:0] ALU_NOT = 4'd14;

    // Instruction opcodes, instr[15:12]; 11..15 are reserved
    localparam logic [3:0] OPC_ADD  = 4'd0;
    localparam logic [3:0] OPC_SUB  = 4'd1;
    localparam logic [3:0] OPC_AND  = 4'd2;
    localparam logic [3:0] OPC_OR   = 4'd3;
    localparam logic [3:0] OPC_XOR  = 4'd4;
    localparam logic [3:0] OPC_SLT  = 4'd5;
    localparam logic [3:0] OPC_SRL  = 4'd6;
    localparam logic [3:0] OPC_SLL  = 4'd7;
    localparam logic [3:0] OPC_NOT  = 4'd8;
    localparam logic [3:0] OPC_LI   = 4'd9;
    localparam logic [3:0] OPC_ADDI = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Source of ALU operand b
    typedef enum logic [1:0] {
        B_REG  = 2'd0,   // rt register value
        B_ZERO = 2'd1,   // constant zero
        B_ZIMM = 2'd2,   // zero-extended immediate
        B_SIMM = 2'd3    // sign-extended immediate
    } b_sel_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] op;
        logic       a_zero;   // operand a forced to zero instead of rs
        b_sel_t     b_sel;
    } decode_t;

    function automatic logic is_legal(input logic [3:0] opc);
        return (opc <= OPC_ADDI);
    endfunction

    function automatic decode_t decode(input logic [3:0] opc);
        decode_t d;
        d = '{legal: 1'b1, op: ALU_ADD, a_zero: 1'b0, b_sel: B_REG};
        case (opc)
            OPC_ADD:  d.op = ALU_ADD;
            OPC_SUB:  d.op = ALU_SUB;
            OPC_AND:  d.op = ALU_AND;
            OPC_OR:   d.op = ALU_OR;
            OPC_XOR:  d.op = ALU_XOR;
            OPC_SLT:  d.op = ALU_SLT;
            OPC_SRL:  d.op = ALU_SRL;
            OPC_SLL:  d.op = ALU_SLL;
            OPC_NOT:  begin d.op = ALU_NOT; d.b_sel = B_ZERO; end
            OPC_LI:   begin d.op = ALU_ADD; d.a_zero = 1'b1; d.b_sel = B_ZIMM; end
            OPC_ADDI: begin d.op = ALU_ADD; d.b_sel = B_SIMM; end
            default:  d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issue_ctrl_reg_file_2r1w.sv
// ============================================================================
// Module      : reg_file_2r1w
// Description : Register file with two asynchronous read ports, one debug
//               read port and one synchronous write port. r0 reads as zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_2r1w #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    localparam int NREG = 2 ** REG_AW;

    logic [DATA_W-1:0] mem [NREG];

    // r0 has no storage; it is a hardwired zero
    assign mem[0] = '0;

    generate
        for (genvar i = 1; i < NREG; i++) begin : g_reg
            // One storage word per register, cleared by reset
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem[i] <= '0;
                end else if (we && (waddr == REG_AW'(i))) begin
                    mem[i] <= wdata;
                end
            end
        end
    endgenerate

    assign ra_data  = mem[ra_addr];
    assign rb_data  = mem[rb_addr];
    assign dbg_data = mem[dbg_addr];

endmodule

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Multi-cycle execute sequencer in front of a combinational
//               16-bit ALU: accept, read operands, execute, write back and
//               hold the result until the consumer takes it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int IMM_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [REG_AW-1:0] res_rd,
    output logic              res_zero,
    output logic              illegal,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_t            state;
    logic [15:0]       instr_q;
    decode_t           dec_q;
    logic [REG_AW-1:0] rd_q;
    logic [REG_AW-1:0] rs_q;
    logic [REG_AW-1:0] rt_q;
    logic [IMM_W-1:0]  imm_q;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] b_next;

    assign dec_q = decode(instr_q[15:12]);
    assign rd_q  = instr_q[9 +: REG_AW];
    assign rs_q  = instr_q[6 +: REG_AW];
    assign rt_q  = instr_q[3 +: REG_AW];
    assign imm_q = instr_q[IMM_W-1:0];

    // Ready is masked while reset is held so nothing is offered before it lifts
    assign instr_ready = (state == ST_IDLE) && !rst;

    reg_file_2r1w #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_rf (
        .clk      (clk),
        .rst      (rst),
        .ra_addr  (rs_q),
        .ra_data  (rs_data),
        .rb_addr  (rt_q),
        .rb_data  (rt_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (state == ST_EXEC),
        .waddr    (rd_q),
        .wdata    (alu_out)
    );

    // Operand b selection for the latched instruction
    always_comb begin
        b_next = rt_data;
        case (dec_q.b_sel)
            B_REG:   b_next = rt_data;
            B_ZERO:  b_next = '0;
            B_ZIMM:  b_next = {{(DATA_W-IMM_W){1'b0}}, imm_q};
            B_SIMM:  b_next = {{(DATA_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};
            default: b_next = rt_data;
        endcase
    end

    // Sequencer: accept, operand read, execute/writeback, result hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            instr_q   <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_rd    <= '0;
            res_zero  <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (instr_valid && instr_ready) begin
                        instr_q <= instr;
                        if (is_legal(instr[15:12])) begin
                            state <= ST_READ;
                        end else begin
                            // Reserved opcode: report straight away, no ALU pass
                            state     <= ST_DONE;
                            res_valid <= 1'b1;
                            illegal   <= 1'b1;
                            res_data  <= '0;
                            res_zero  <= 1'b0;
                            res_rd    <= instr[9 +: REG_AW];
                        end
                    end
                end
                ST_READ: begin
                    if (dec_q.legal) begin
                        alu_a  <= dec_q.a_zero ? '0 : rs_data;
                        alu_b  <= b_next;
                        alu_op <= dec_q.op;
                    end
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    res_data  <= alu_out;
                    res_zero  <= alu_zero;
                    res_rd    <= rd_q;
                    illegal   <= 1'b0;
                    res_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Directed self-checking bench for alu_issue_ctrl with a
//               behavioural ALU attached to the a/b/op interface.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;
    logic [15:0] alu_out;
    logic        alu_zero;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [2:0]  res_rd;
    logic        res_zero;
    logic        illegal;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_checks = 0;
    int n_err    = 0;

    alu_issue_ctrl #(.DATA_W(16), .REG_AW(3), .IMM_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_out     (alu_out),
        .alu_zero    (alu_zero),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_rd      (res_rd),
        .res_zero    (res_zero),
        .illegal     (illegal),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    // Behavioural combinational ALU
    always_comb begin
        alu_out = 16'h0000;
        case (alu_op)
            4'd0:    alu_out = alu_a + alu_b;
            4'd1:    alu_out = alu_a - alu_b;
            4'd2:    alu_out = alu_a & alu_b;
            4'd4:    alu_out = alu_a | alu_b;
            4'd6:    alu_out = alu_a ^ alu_b;
            4'd7:    alu_out = ($signed(alu_a) < $signed(alu_b)) ? 16'd1 : 16'd0;
            4'd8:    alu_out = alu_a >> alu_b[3:0];
            4'd12:   alu_out = alu_a << alu_b[3:0];
            4'd14:   alu_out = ~alu_a;
            default: alu_out = 16'h0000;
        endcase
        alu_zero = (alu_out == 16'h0000);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input logic [2:0] r, input logic [15:0] exp);
        dbg_addr = r;
        #1;
        check($sformatf("dbg_r%0d", r), dbg_data, exp);
    endtask

    // Issue one instruction and check each cycle of its life; hold>0 keeps
    // res_ready low for that many cycles after the result appears
    task automatic issue(input string nm, input logic [15:0] ins, input logic ill,
                         input logic [3:0] eop, input logic [15:0] ea, input logic [15:0] eb,
                         input logic [15:0] edata, input logic ezero, input logic [2:0] erd,
                         input int hold);
        @(negedge clk);
        check({nm, ":ready_idle"}, instr_ready, 1'b1);
        instr       = ins;
        instr_valid = 1'b1;
        res_ready   = (hold == 0);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        if (!ill) begin
            check({nm, ":t1_valid"}, res_valid, 1'b0);
            check({nm, ":t1_ready"}, instr_ready, 1'b0);
            @(posedge clk);
            #1;
            check({nm, ":t2_valid"}, res_valid, 1'b0);
            check({nm, ":alu_op"}, alu_op, eop);
            check({nm, ":alu_a"}, alu_a, ea);
            check({nm, ":alu_b"}, alu_b, eb);
            @(posedge clk);
            #1;
            check({nm, ":res_zero"}, res_zero, ezero);
        end
        check({nm, ":res_valid"}, res_valid, 1'b1);
        check({nm, ":illegal"}, illegal, ill);
        check({nm, ":res_data"}, res_data, edata);
        check({nm, ":res_rd"}, res_rd, erd);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({nm, ":hold_valid"}, res_valid, 1'b1);
            check({nm, ":hold_data"}, res_data, edata);
            check({nm, ":hold_ready"}, instr_ready, 1'b0);
        end
        if (hold > 0) begin
            @(negedge clk);
            res_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check({nm, ":drop_valid"}, res_valid, 1'b0);
        check({nm, ":back_idle"}, instr_ready, 1'b1);
    endtask

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        res_ready   = 1'b1;
        dbg_addr    = 3'd1;

        // Reset state
        #12;
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_res_data", res_data, 16'h0000);
        check("rst_alu_a", alu_a, 16'h0000);
        check("rst_alu_op", alu_op, 4'd0);
        check("rst_illegal", illegal, 1'b0);
        check("rst_ready_held", instr_ready, 1'b0);
        check("rst_dbg_r1", dbg_data, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready_after", instr_ready, 1'b1);

        //    name          instr    ill op     a        b        data     z     rd  hold
        issue("li_r1",      16'h9205, 0, 4'd0,  16'd0,   16'd5,   16'd5,   1'b0, 3'd1, 0);
        issue("li_r2",      16'h9403, 0, 4'd0,  16'd0,   16'd3,   16'd3,   1'b0, 3'd2, 0);
        issue("add_r3",     16'h0650, 0, 4'd0,  16'd5,   16'd3,   16'd8,   1'b0, 3'd3, 0);
        check_reg(3'd3, 16'd8);
        issue("sub_r4",     16'h1848, 0, 4'd1,  16'd5,   16'd5,   16'd0,   1'b1, 3'd4, 0);
        issue("slt_lt",     16'h5A88, 0, 4'd7,  16'd3,   16'd5,   16'd1,   1'b0, 3'd5, 0);
        issue("slt_ge",     16'h5A50, 0, 4'd7,  16'd5,   16'd3,   16'd0,   1'b1, 3'd5, 0);
        issue("sll_r6",     16'h7C50, 0, 4'd12, 16'd5,   16'd3,   16'd40,  1'b0, 3'd6, 0);
        issue("srl_r6",     16'h6D90, 0, 4'd8,  16'd40,  16'd3,   16'd5,   1'b0, 3'd6, 0);
        issue("not_r7",     16'h8E00, 0, 4'd14, 16'd0,   16'd0,   16'hFFFF,1'b0, 3'd7, 0);
        issue("addi_neg",   16'hA87E, 0, 4'd0,  16'd5,   16'hFFFE,16'd3,   1'b0, 3'd4, 0);
        issue("and_r4",     16'h2850, 0, 4'd2,  16'd5,   16'd3,   16'd1,   1'b0, 3'd4, 0);
        issue("or_r4",      16'h3850, 0, 4'd4,  16'd5,   16'd3,   16'd7,   1'b0, 3'd4, 0);
        issue("xor_r4",     16'h4850, 0, 4'd6,  16'd5,   16'd3,   16'd6,   1'b0, 3'd4, 0);
        issue("add_hold",   16'h0650, 0, 4'd0,  16'd5,   16'd3,   16'd8,   1'b0, 3'd3, 5);
        issue("illegal_f",  16'hF200, 1, 4'd0,  16'd0,   16'd0,   16'd0,   1'b0, 3'd1, 0);

        // Register contents after the illegal op: nothing changed
        check_reg(3'd1, 16'd5);
        check_reg(3'd2, 16'd3);
        check_reg(3'd3, 16'd8);
        check_reg(3'd4, 16'd6);
        check_reg(3'd5, 16'd0);
        check_reg(3'd6, 16'd5);
        check_reg(3'd7, 16'hFFFF);

        issue("add_r0",     16'h0050, 0, 4'd0,  16'd5,   16'd3,   16'd8,   1'b0, 3'd0, 0);
        check_reg(3'd0, 16'd0);

        // Reset in the middle of EXEC aborts the instruction
        @(negedge clk);
        instr       = 16'h9207;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_res_valid", res_valid, 1'b0);
        check("abort_alu_a", alu_a, 16'h0000);
        check("abort_alu_b", alu_b, 16'h0000);
        check("abort_res_data", res_data, 16'h0000);
        check_reg(3'd1, 16'd0);
        check_reg(3'd7, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ready", instr_ready, 1'b1);
        @(posedge clk);
        #1;
        check("abort_no_result1", res_valid, 1'b0);
        @(posedge clk);
        #1;
        check("abort_no_result2", res_valid, 1'b0);
        check_reg(3'd1, 16'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
